// File: rtl/strip_stream_pkg.sv
// rtl/strip_stream_pkg.sv - geometry, register map and state types for the strip pixel streamer
package strip_stream_pkg;

    localparam int CAP_X0          = 208;
    localparam int CAP_Y0          = 128;
    localparam int CAP_W           = 224;
    localparam int STRIP_H         = 8;
    localparam int NUM_STRIPS      = 28;
    localparam int WORDS_PER_STRIP = 448;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_DATA   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  y;
        logic [10:0] x;
        logic [10:0] row;
        logic        last;
    } pixel_t;

    // STATUS reports the state one-hot with IDLE in bit 0.
    function automatic logic [3:0] state_onehot(input state_t s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/strip_buffer.sv
// rtl/strip_buffer.sv - 448x32 simple dual-port strip RAM with registered read
module strip_buffer
    import strip_stream_pkg::*;
(
    input  logic        clk,
    input  logic        wr_en,
    input  logic [8:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    input  logic [8:0]  rd_addr,
    output logic [31:0] rd_data
);

    logic [31:0] mem [WORDS_PER_STRIP];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/strip_pixel_streamer.sv
// rtl/strip_pixel_streamer.sv - register-loaded strip buffer streamed out as screen pixels
module strip_pixel_streamer
    import strip_stream_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  addr,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [7:0]  pix_y,
    output logic [10:0] pix_x,
    output logic [10:0] pix_row,
    output logic        pix_last
);

    localparam logic [7:0] COL_LAST      = 8'(CAP_W - 1);
    localparam logic [2:0] ROW_LAST      = 3'(STRIP_H - 1);
    localparam logic [8:0] WORD_LAST     = 9'(WORDS_PER_STRIP - 1);
    localparam logic [7:0] STRIP_MAX     = 8'(NUM_STRIPS - 1);
    localparam logic [8:0] WORDS_PER_ROW = 9'(CAP_W / 4);

    state_t      state, state_next;
    logic [8:0]  word_count;
    logic [7:0]  strip_q;
    logic        err_strip, err_overflow;

    logic        ctrl_wr, data_wr, start, abort;
    logic        accept_start, bad_start, store_word, overflow;

    logic [7:0]  f_col;
    logic [2:0]  f_row;
    logic        f_done, issue;
    logic [8:0]  rd_addr;
    logic [31:0] ram_q;
    logic [2:0]  occ_after_pop;

    logic        inf_valid, inf_last;
    logic [7:0]  inf_col;
    logic [2:0]  inf_row;

    pixel_t      fifo_mem [2];
    pixel_t      head, push_pix;
    logic        wptr, rptr, pop;
    logic [1:0]  count;

    assign ctrl_wr = wr_en && (addr == ADDR_CTRL);
    assign data_wr = wr_en && (addr == ADDR_DATA);
    assign start   = ctrl_wr && writedata[0];
    assign abort   = ctrl_wr && writedata[1];

    assign head      = fifo_mem[rptr];
    assign pix_valid = (count != 2'd0);
    assign pop       = pix_valid && pix_ready;
    assign pix_y     = pix_valid ? head.y    : 8'd0;
    assign pix_x     = pix_valid ? head.x    : 11'd0;
    assign pix_row   = pix_valid ? head.row  : 11'd0;
    assign pix_last  = pix_valid && head.last;

    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        bad_start    = 1'b0;
        store_word   = 1'b0;
        overflow     = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            if (start) begin
                if (writedata[15:8] > STRIP_MAX) begin
                    bad_start = 1'b1;
                end else if (state == ST_IDLE || state == ST_DONE) begin
                    accept_start = 1'b1;
                    state_next   = ST_LOAD;
                end
            end
            if (data_wr) begin
                if (state == ST_LOAD) begin
                    store_word = 1'b1;
                    if (word_count == WORD_LAST) begin
                        state_next = ST_STREAM;
                    end
                end else begin
                    overflow = 1'b1;
                end
            end
            if (state == ST_STREAM && pop && head.last) begin
                state_next = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_count   <= 9'd0;
            strip_q      <= 8'd0;
            err_strip    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (accept_start) begin
                strip_q      <= writedata[15:8];
                word_count   <= 9'd0;
                err_strip    <= 1'b0;
                err_overflow <= 1'b0;
            end
            if (bad_start) begin
                err_strip <= 1'b1;
            end
            if (store_word) begin
                word_count <= word_count + 9'd1;
            end
            if (overflow) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Fetch only when the RAM result is guaranteed a FIFO slot: the slot
    // freed by this cycle's pop counts, which keeps one pixel per cycle
    // flowing through two entries despite the read latency.
    assign occ_after_pop = 3'(count) + 3'(inf_valid) - 3'(pop);
    assign issue   = (state == ST_STREAM) && !f_done && (occ_after_pop <= 3'd1);
    assign rd_addr = 9'(f_row) * WORDS_PER_ROW + 9'(f_col[7:2]);

    strip_buffer u_buffer (
        .clk     (clk),
        .wr_en   (store_word),
        .wr_addr (word_count),
        .wr_data (writedata),
        .rd_en   (issue),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    always_comb begin
        push_pix.y    = ram_q[8*inf_col[1:0] +: 8];
        push_pix.x    = 11'(CAP_X0) + 11'(inf_col);
        push_pix.row  = 11'(CAP_Y0) + {strip_q, 3'b000} + 11'(inf_row);
        push_pix.last = inf_last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_col     <= 8'd0;
            f_row     <= 3'd0;
            f_done    <= 1'b0;
            inf_valid <= 1'b0;
            inf_col   <= 8'd0;
            inf_row   <= 3'd0;
            inf_last  <= 1'b0;
            count     <= 2'd0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
        end else if (state_next != ST_STREAM) begin
            // Leaving or not yet in STREAM flushes everything in flight.
            f_col     <= 8'd0;
            f_row     <= 3'd0;
            f_done    <= 1'b0;
            inf_valid <= 1'b0;
            count     <= 2'd0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
        end else begin
            inf_valid <= issue;
            if (issue) begin
                inf_col  <= f_col;
                inf_row  <= f_row;
                inf_last <= (f_col == COL_LAST) && (f_row == ROW_LAST);
                if (f_col == COL_LAST) begin
                    f_col <= 8'd0;
                    if (f_row == ROW_LAST) begin
                        f_done <= 1'b1;
                    end else begin
                        f_row <= f_row + 3'd1;
                    end
                end else begin
                    f_col <= f_col + 8'd1;
                end
            end
            if (inf_valid) begin
                wptr <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            count <= count + 2'(inf_valid) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (inf_valid) begin
            fifo_mem[wptr] <= push_pix;
        end
    end

    always_comb begin
        readdata = 32'd0;
        if (rd_en) begin
            case (addr)
                ADDR_CTRL:   readdata = {16'd0, strip_q, 8'd0};
                ADDR_STATUS: readdata = {7'd0, word_count, strip_q, 2'b00,
                                         err_strip, err_overflow, state_onehot(state)};
                default:     readdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_strip_pixel_streamer.sv
// tb/tb_strip_pixel_streamer.sv - self-checking bench for strip_pixel_streamer
module tb_strip_pixel_streamer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  addr;
    logic        rd_en, wr_en;
    logic [31:0] writedata, readdata;
    logic        pix_valid, pix_ready;
    logic [7:0]  pix_y;
    logic [10:0] pix_x, pix_row;
    logic        pix_last;

    int checks = 0;
    int errors = 0;
    logic [31:0] mdl_words [448];
    int last_row;

    typedef struct {
        bit          wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] mask;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    strip_pixel_streamer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .addr      (addr),
        .rd_en     (rd_en),
        .wr_en     (wr_en),
        .writedata (writedata),
        .readdata  (readdata),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_y     (pix_y),
        .pix_x     (pix_x),
        .pix_row   (pix_row),
        .pix_last  (pix_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        writedata = d;
        wr_en = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        rd_en = 1'b1;
        #1;
        d = readdata;
        rd_en = 1'b0;
    endtask

    function automatic vec_t mk(input bit wr, input logic [1:0] wa, input logic [31:0] wd,
                                input logic [1:0] ra, input logic [31:0] m,
                                input logic [31:0] e, input string n);
        vec_t v;
        v.wr = wr; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.mask = m; v.exp = e; v.name = n;
        return v;
    endfunction

    // Pixel n of a strip: raster order over a 224x8 window, byte n of the loaded words.
    function automatic logic [30:0] exp_pix(input int n, input int strip);
        int r, c;
        logic [31:0] w;
        logic [7:0] y;
        r = n / 224;
        c = n % 224;
        w = mdl_words[n / 4];
        y = w[8 * (n % 4) +: 8];
        return {y, 11'(208 + c), 11'(128 + 8 * strip + r), (n == 1791)};
    endfunction

    // stop_kind: 0 run to completion, 1 abort after stop_at pixels, 2 reset after stop_at pixels
    task automatic run_stream(input int strip, input bit rand_data, input bit rand_ready,
                              input bit extra_wr, input int stop_kind, input int stop_at);
        int n, k, first_k, last_k;
        bit done, prev_stall;
        logic [30:0] cur, prev_out;
        logic [31:0] st;
        for (int i = 0; i < 448; i++) begin
            mdl_words[i] = rand_data ? $urandom :
                           {8'(4 * i + 3), 8'(4 * i + 2), 8'(4 * i + 1), 8'(4 * i)};
        end
        bus_write(2'd0, (32'(strip) << 8) | 32'h1);
        for (int i = 0; i < 448; i++) begin
            bus_write(2'd1, mdl_words[i]);
        end
        n = 0; k = 0; first_k = -1; last_k = -1; done = 0; prev_stall = 0; prev_out = '0;
        while (!done && k < 20000) begin
            @(negedge clk);
            wr_en = 1'b0;
            if (k == 0 && extra_wr) begin
                addr = 2'd1;
                writedata = 32'hDEADBEEF;
                wr_en = 1'b1;
            end
            if (stop_kind == 1 && n == stop_at) begin
                pix_ready = 1'b0;
                addr = 2'd0;
                writedata = 32'h2;
                wr_en = 1'b1;
                @(negedge clk);
                wr_en = 1'b0;
                #1;
                check("abort_valid_low", 64'(pix_valid), 64'd0);
                check("abort_outputs_zero", 64'({pix_y, pix_x, pix_row, pix_last}), 64'd0);
                bus_read(2'd2, st);
                check("abort_state_idle", 64'(st[3:0]), 64'h1);
                pix_ready = 1'b1;
                return;
            end
            if (stop_kind == 2 && n == stop_at) begin
                reset_n = 1'b0;
                #1;
                check("reset_valid_low", 64'(pix_valid), 64'd0);
                check("reset_outputs_zero", 64'({pix_y, pix_x, pix_row, pix_last}), 64'd0);
                @(negedge clk);
                @(negedge clk);
                reset_n = 1'b1;
                bus_read(2'd2, st);
                check("reset_status", 64'(st), 64'h1);
                pix_ready = 1'b1;
                return;
            end
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            cur = {pix_y, pix_x, pix_row, pix_last};
            if (prev_stall) check("stall_hold", 64'(cur), 64'(prev_out));
            if (!pix_valid) check("idle_zero", 64'(cur), 64'd0);
            if (pix_valid && first_k < 0) first_k = k;
            if (pix_valid && pix_ready) begin
                check($sformatf("pixel_%0d", n), 64'(cur), 64'(exp_pix(n, strip)));
                if (n == 1791) begin
                    done = 1;
                    last_k = k;
                    last_row = int'(pix_row);
                end
                n++;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_out = cur;
            k++;
        end
        pix_ready = 1'b1;
        if (!done) begin
            check("stream_timeout_pixels", 64'(n), 64'd1792);
            return;
        end
        check("first_valid_latency_ok", 64'(first_k >= 0 && first_k <= 3), 64'd1);
        if (!rand_ready) check("no_bubbles", 64'(last_k - first_k), 64'd1791);
        @(negedge clk);
        #1;
        check("valid_drops_after_last", 64'(pix_valid), 64'd0);
        bus_read(2'd2, st);
        check("done_status", 64'(st),
              64'({7'd0, 9'd448, 8'(strip), 2'b00, 1'b0, extra_wr, 4'b1000}));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        reset_n = 1'b0; addr = 2'd0; rd_en = 1'b0; wr_en = 1'b0;
        writedata = 32'd0; pix_ready = 1'b1;

        tbl[0]  = mk(0, 2'd0, 32'h0,        2'd2, 32'hFFFFFFFF, 32'h00000001, "reset_status");
        tbl[1]  = mk(0, 2'd0, 32'h0,        2'd3, 32'hFFFFFFFF, 32'h00000000, "reserved_read");
        tbl[2]  = mk(1, 2'd1, 32'h12345678, 2'd2, 32'hFFFFFFFF, 32'h00000011, "data_in_idle");
        tbl[3]  = mk(1, 2'd0, 32'h00001C01, 2'd2, 32'hFFFFFFFF, 32'h00000031, "bad_strip_28");
        tbl[4]  = mk(1, 2'd0, 32'h00000001, 2'd2, 32'hFFFFFFFF, 32'h00000002, "start_clears_err");
        tbl[5]  = mk(1, 2'd1, 32'hA5A5A5A5, 2'd2, 32'hFFFFFFFF, 32'h00010002, "load_word1");
        tbl[6]  = mk(1, 2'd1, 32'h5A5A5A5A, 2'd2, 32'hFFFFFFFF, 32'h00020002, "load_word2");
        tbl[7]  = mk(1, 2'd0, 32'h00000501, 2'd2, 32'hFFFFFFFF, 32'h00020002, "start_in_load");
        tbl[8]  = mk(1, 2'd3, 32'hFFFFFFFF, 2'd2, 32'hFFFFFFFF, 32'h00020002, "reserved_write");
        tbl[9]  = mk(1, 2'd0, 32'h00000403, 2'd2, 32'h0000FFFF, 32'h00000001, "abort_beats_start");
        tbl[10] = mk(1, 2'd0, 32'h00001B01, 2'd2, 32'hFFFFFFFF, 32'h00001B02, "start_strip27");
        tbl[11] = mk(1, 2'd0, 32'h00000002, 2'd2, 32'h0000FFFF, 32'h00001B01, "abort_load");
        tbl[12] = mk(1, 2'd0, 32'h0000FF01, 2'd2, 32'h0000FFFF, 32'h00001B21, "bad_strip_255");
        tbl[13] = mk(1, 2'd1, 32'h0BADF00D, 2'd2, 32'h0000FFFF, 32'h00001B31, "data_after_abort");

        #1;
        check("reset_valid", 64'(pix_valid), 64'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].waddr, tbl[i].wdata);
            bus_read(tbl[i].raddr, rd);
            check(tbl[i].name, 64'(rd & tbl[i].mask), 64'(tbl[i].exp));
        end

        @(negedge clk);
        addr = 2'd2;
        #1;
        check("readdata_without_rd_en", 64'(readdata), 64'd0);

        run_stream(3, 0, 0, 0, 0, 0);
        run_stream(3, 0, 1, 0, 0, 0);
        run_stream(int'($urandom_range(0, 27)), 1, 1, 1, 0, 0);
        run_stream(10, 0, 0, 0, 1, 100);
        last_row = 0;
        run_stream(27, 1, 0, 0, 0, 0);
        check("strip27_last_row", 64'(last_row), 64'd351);
        run_stream(5, 1, 1, 0, 2, 50);
        run_stream(0, 1, 1, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strip_pixel_streamer.md
STRIP_PIXEL_STREAMER -- requirements
Module: strip_pixel_streamer

Interface
REQ-001 The block SHALL have these ports: clk  in  1  system clock (100 MHz), all logic on rising edge.
REQ-002 reset_n  in  1  asynchronous active-low reset.
REQ-003 addr  in  2  Avalon-MM register address.
REQ-004 rd_en  in  1  Avalon-MM read strobe.
REQ-005 wr_en  in  1  Avalon-MM write strobe.
REQ-006 writedata  in  32  Avalon-MM write data.
REQ-007 readdata  out  32  Avalon-MM read data.
REQ-008 pix_valid  out  1  output pixel valid.
REQ-009 pix_ready  in  1  downstream accepts pixel.
REQ-010 pix_y  out  8  luma sample.
REQ-011 pix_x  out  11  screen X coordinate.
REQ-012 pix_row  out  11  screen Y coordinate.
REQ-013 pix_last  out  1  final pixel of strip.
REQ-014 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-015 Register map SHALL be: addr 0 CTRL (write: bit0 start, bit1 abort, bits[15:8] strip_number); addr 1 DATA (write: four pixels, writedata[7:0] lowest X); addr 2 STATUS (read-only); addr 3 reserved (reads 0, writes ignored).
REQ-016 STATUS SHALL read {word_count[8:0] at bits[24:16], strip_number at bits[15:8], 2'b0, err_strip, err_overflow, state[3:0] one-hot IDLE/LOAD/STREAM/DONE}.
REQ-017 readdata SHALL be combinational, equal to the addressed register while rd_en=1 and 0 otherwise.
REQ-018 The FSM SHALL have states IDLE, LOAD, STREAM, DONE.
REQ-019 A CTRL write with start=1 and strip_number<=27 SHALL, from IDLE or DONE, latch strip_number, clear word_count, and enter LOAD on the next cycle.
REQ-020 A start with strip_number>27 SHALL be ignored and SHALL set sticky err_strip.
REQ-021 A start received in LOAD or STREAM SHALL be ignored.
REQ-022 A CTRL write with abort=1 SHALL return the FSM to IDLE from any state next cycle, deassert pix_valid, and take priority over a simultaneous start.
REQ-023 In LOAD, each DATA write SHALL store the word at buffer index word_count and increment word_count.
REQ-024 When the 448th word (word_count=447) is written, the FSM SHALL enter STREAM.
REQ-025 DATA writes outside LOAD SHALL be discarded and SHALL set sticky err_overflow.
REQ-026 err_strip and err_overflow SHALL clear only on a successful start or on reset.
REQ-027 In STREAM, pixels SHALL be emitted in row-major order: row r 0..7, column c 0..223; pix_x=208+c; pix_row=128+8*strip_number+r.
REQ-028 Handshake: a pixel transfers on a cycle with pix_valid=1 and pix_ready=1; while pix_valid=1 and pix_ready=0, all pix_* outputs SHALL hold stable.
REQ-029 pix_valid SHALL first assert no later than 3 cycles after STREAM entry.
REQ-030 With pix_ready held high, sustained throughput SHALL be one pixel per cycle, with no bubbles after the first pixel.
REQ-031 pix_last SHALL be 1 only with pixel (c=223, r=7); its transfer SHALL move the FSM to DONE and deassert pix_valid next cycle.
REQ-032 Outputs pix_y, pix_x, pix_row, and pix_last SHALL be 0 whenever pix_valid=0.
REQ-033 The column counter SHALL wrap from 223 to 0 with a row increment; the row counter SHALL saturate at 7.
REQ-034 Coordinate arithmetic SHALL be unsigned 11-bit; 128+8*27+7=351 SHALL not overflow.

Reset
REQ-035 Asserting reset_n=0 SHALL immediately force: state IDLE, pix_valid=0, all pix_* outputs 0, word_count 0, strip_number 0, and err flags 0.
REQ-036 Reset mid-LOAD or mid-STREAM SHALL discard the partial strip.
REQ-037 Buffer contents need not be reset.
REQ-038 Reset deassertion SHALL be synchronized to clk by the instantiating top level.

Structure
REQ-039 Package strip_stream_pkg SHALL hold CAP_X0=208, CAP_Y0=128, CAP_W=224, STRIP_H=8, NUM_STRIPS=28, WORDS_PER_STRIP=448, register address constants, and the state enum.
REQ-040 The 448x32 simple dual-port RAM SHALL be sub-module strip_buffer, with 1-cycle registered read and no reset.
REQ-041 The output stage SHALL contain a two-entry skid buffer to meet REQ-028 and REQ-030 despite RAM latency.

Verification
REQ-042 Scenario: start strip 3, write 448 words of incrementing bytes (0x03020100, ...), pix_ready=1 -> 1792 pixels in order; the first pixel is x=208, row=152, y=0x00; the last is x=431, row=159, y=0xFF (byte 1791 mod 256); pix_last only on the last; DONE follows.
REQ-043 Scenario: as REQ-042 with pix_ready toggled pseudo-randomly -> identical pixel sequence, and outputs stable on every stalled cycle.
REQ-044 Scenario: start with strip_number=28 -> state remains IDLE and STATUS bit5 (err_strip)=1; then a start with strip 0 -> err_strip cleared, LOAD entered.
REQ-045 Scenario: DATA write in IDLE -> err_overflow=1, word_count=0; a 449th write after STREAM entry -> err_overflow=1, stream unaffected.
REQ-046 Scenario: abort after 100 pixels transferred -> pix_valid=0 next cycle, state IDLE; new start on strip 27 -> last pixel row=351.
REQ-047 Scenario: reset_n pulsed low mid-STREAM -> pix_valid=0 immediately during reset, STATUS reads 0x00000001 after release.
